uart_cmd_frame_rx: RTL and testbench

Parametrised 8N1 UART receiver and command-frame parser for the RS-485 host link. It oversamples the serial line and assembles bytes. Bytes are validated against the frame format sync 0xAA, DEV_ADDR, CMD, LEN, payload, XOR checksum, tail 0x55. Each good frame is delivered once through a valid/ack handshake to the command executors (read, baud-switch and future commands); bad frames produce a one-cycle error pulse with a cause code.

---
 rtl/uart_cmd_frame_rx.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_cmd_frame_rx.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_frame_rx.sv
// 8N1 UART receiver and command-frame parser for the RS-485 host link.
// Latency: byte strobe at start-edge + OVERSAMPLE/2 + 9*OVERSAMPLE + 1; frame_valid/err one cycle after that strobe.
// Backpressure: a held frame blocks the next delivery; a frame completing while one is held is dropped with err 7.
module uart_cmd_frame_rx #(
  parameter int          OVERSAMPLE  = 8,
  parameter int          MAX_PAYLOAD = 12,
  parameter logic [7:0]  DEV_ADDR    = 8'h02,
  parameter int          TIMEOUT_CYC = 4096
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     f_rx,
  output logic                     frame_valid,
  input  logic                     frame_ack,
  output logic [7:0]               cmd,
  output logic [7:0]               cmd_len,
  output logic [8*MAX_PAYLOAD-1:0] payload,
  output logic                     err,
  output logic [2:0]               err_code,
  output logic                     busy
);

  localparam int BCW = $clog2(OVERSAMPLE + 1);
  localparam int TW  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {P_SYNC, P_ADDR, P_CMD, P_LEN, P_PAY, P_CHK, P_TAIL} p_state_e;

  // Receiver state
  logic            sync1_q, sync2_q, rx_prev_q;
  rx_state_e       rx_state_q, rx_state_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_stb_q, byte_stb_d;
  logic            ferr_stb_q, ferr_stb_d;
  logic            rx_s;

  // Parser state
  p_state_e                 p_state_q, p_state_d;
  logic [7:0]               wcmd_q, wcmd_d;
  logic [7:0]               wlen_q, wlen_d;
  logic [8*MAX_PAYLOAD-1:0] wpay_q, wpay_d;
  logic [7:0]               idx_q, idx_d;
  logic [7:0]               chk_q, chk_d;
  logic [TW-1:0]            to_q, to_d;
  logic                     fv_q, fv_d;
  logic [7:0]               cmd_q, cmd_d;
  logic [7:0]               cmd_len_q, cmd_len_d;
  logic [8*MAX_PAYLOAD-1:0] payload_q, payload_d;
  logic                     err_q, err_d;
  logic [2:0]               err_code_q, err_code_d;

  assign rx_s = sync2_q;

  // Bit timing: bcnt counts cycles inside the current bit; samples land mid-bit.
  always_comb begin
    rx_state_d = rx_state_q;
    bcnt_d     = bcnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    byte_stb_d = 1'b0;
    ferr_stb_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_s && rx_prev_q) begin
          rx_state_d = RX_START;
          bcnt_d     = BCW'(1);
        end
      end
      RX_START: begin
        if (bcnt_q == BCW'(OVERSAMPLE / 2)) begin
          if (rx_s) begin
            rx_state_d = RX_IDLE;          // glitch, not a real start bit
          end else begin
            rx_state_d = RX_DATA;
            bcnt_d     = BCW'(1);
            bit_idx_d  = 3'd0;
          end
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      RX_DATA: begin
        if (bcnt_q == BCW'(OVERSAMPLE)) begin
          shift_d = {rx_s, shift_q[7:1]};
          bcnt_d  = BCW'(1);
          if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
          else                   bit_idx_d  = bit_idx_q + 3'd1;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      RX_STOP: begin
        if (bcnt_q == BCW'(OVERSAMPLE)) begin
          rx_state_d = RX_IDLE;
          if (rx_s) byte_stb_d = 1'b1;
          else      ferr_stb_d = 1'b1;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Synchroniser, edge history and receiver registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      bcnt_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_stb_q <= 1'b0;
      ferr_stb_q <= 1'b0;
    end else begin
      sync1_q    <= f_rx;
      sync2_q    <= sync1_q;
      rx_prev_q  <= sync2_q;
      rx_state_q <= rx_state_d;
      bcnt_q     <= bcnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      byte_stb_q <= byte_stb_d;
      ferr_stb_q <= ferr_stb_d;
    end
  end

  // Frame parser: advances on byte strobes, handles delivery, ack and timeout.
  always_comb begin
    p_state_d  = p_state_q;
    wcmd_d     = wcmd_q;
    wlen_d     = wlen_q;
    wpay_d     = wpay_q;
    idx_d      = idx_q;
    chk_d      = chk_q;
    fv_d       = fv_q;
    cmd_d      = cmd_q;
    cmd_len_d  = cmd_len_q;
    payload_d  = payload_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    // Cleared in SYNC and on every byte; err registers one cycle after the
    // hit, so the hit is taken one count early to land at TIMEOUT_CYC.
    to_d = (p_state_q == P_SYNC || byte_stb_q) ? '0 : to_q + TW'(1);

    if (fv_q && frame_ack) fv_d = 1'b0;

    if (ferr_stb_q) begin
      err_d = 1'b1; err_code_d = 3'd5; p_state_d = P_SYNC;
    end else if (byte_stb_q) begin
      case (p_state_q)
        P_SYNC: if (shift_q == 8'hAA) begin
          p_state_d = P_ADDR;
          wpay_d    = '0;
        end
        P_ADDR: begin
          if (shift_q != DEV_ADDR) begin
            err_d = 1'b1; err_code_d = 3'd1; p_state_d = P_SYNC;
          end else p_state_d = P_CMD;
        end
        P_CMD: begin
          wcmd_d = shift_q; chk_d = shift_q; p_state_d = P_LEN;
        end
        P_LEN: begin
          if (shift_q > 8'(MAX_PAYLOAD)) begin
            err_d = 1'b1; err_code_d = 3'd2; p_state_d = P_SYNC;
          end else begin
            wlen_d    = shift_q;
            chk_d     = chk_q ^ shift_q;
            idx_d     = 8'd0;
            p_state_d = (shift_q == 8'd0) ? P_CHK : P_PAY;
          end
        end
        P_PAY: begin
          for (int k = 0; k < MAX_PAYLOAD; k++)
            if (idx_q == 8'(k)) wpay_d[8*k +: 8] = shift_q;
          chk_d = chk_q ^ shift_q;
          idx_d = idx_q + 8'd1;
          if (idx_q + 8'd1 == wlen_q) p_state_d = P_CHK;
        end
        P_CHK: begin
          if (shift_q != chk_q) begin
            err_d = 1'b1; err_code_d = 3'd3; p_state_d = P_SYNC;
          end else p_state_d = P_TAIL;
        end
        P_TAIL: begin
          p_state_d = P_SYNC;
          if (shift_q != 8'h55) begin
            err_d = 1'b1; err_code_d = 3'd4;
          end else if (!fv_q || frame_ack) begin
            fv_d      = 1'b1;
            cmd_d     = wcmd_q;
            cmd_len_d = wlen_q;
            for (int k = 0; k < MAX_PAYLOAD; k++)
              payload_d[8*k +: 8] = (8'(k) < wlen_q) ? wpay_q[8*k +: 8] : 8'h00;
          end else begin
            err_d = 1'b1; err_code_d = 3'd7;   // consumer still holds the previous frame
          end
        end
        default: p_state_d = P_SYNC;
      endcase
    end else if (p_state_q != P_SYNC && to_q == TW'(TIMEOUT_CYC - 2)) begin
      err_d = 1'b1; err_code_d = 3'd6; p_state_d = P_SYNC;
    end
  end

  // Parser and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_state_q  <= P_SYNC;
      wcmd_q     <= 8'h00;
      wlen_q     <= 8'h00;
      wpay_q     <= '0;
      idx_q      <= 8'h00;
      chk_q      <= 8'h00;
      to_q       <= '0;
      fv_q       <= 1'b0;
      cmd_q      <= 8'h00;
      cmd_len_q  <= 8'h00;
      payload_q  <= '0;
      err_q      <= 1'b0;
      err_code_q <= 3'd0;
    end else begin
      p_state_q  <= p_state_d;
      wcmd_q     <= wcmd_d;
      wlen_q     <= wlen_d;
      wpay_q     <= wpay_d;
      idx_q      <= idx_d;
      chk_q      <= chk_d;
      to_q       <= to_d;
      fv_q       <= fv_d;
      cmd_q      <= cmd_d;
      cmd_len_q  <= cmd_len_d;
      payload_q  <= payload_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  assign frame_valid = fv_q;
  assign cmd         = cmd_q;
  assign cmd_len     = cmd_len_q;
  assign payload     = payload_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign busy        = (p_state_q != P_SYNC);

endmodule

// File: tb/tb_uart_cmd_frame_rx.sv
// Scoreboard bench for uart_cmd_frame_rx: directed frames drive the line,
// expected frames/errors are queued, a negedge monitor pops and compares.
module tb_uart_cmd_frame_rx;
  localparam int OS = 8;
  localparam int MP = 12;
  localparam int TO = 256;
  // Sync (2) + mid start bit + 9 bit periods + 1 strobe register.
  localparam int STB_LAT = 2 + OS/2 + 9*OS + 1;

  logic            clk, rst, f_rx, frame_ack;
  logic            frame_valid, err, busy;
  logic [7:0]      cmd, cmd_len;
  logic [8*MP-1:0] payload;
  logic [2:0]      err_code;

  uart_cmd_frame_rx #(.OVERSAMPLE(OS), .MAX_PAYLOAD(MP), .DEV_ADDR(8'h02), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .f_rx(f_rx), .frame_valid(frame_valid), .frame_ack(frame_ack),
    .cmd(cmd), .cmd_len(cmd_len), .payload(payload), .err(err), .err_code(err_code), .busy(busy)
  );

  typedef struct {
    bit              is_err;
    logic [2:0]      code;
    logic [7:0]      cmd;
    logic [7:0]      len;
    logic [8*MP-1:0] pay;
    int              exp_cyc;   // 0: arrival cycle not checked
    bit              chk_idle;  // busy must read 0 with the err
  } exp_t;

  exp_t       exp_q[$];
  int         tests = 0, failed = 0;
  int         cyc = 0;
  int         last_t0 = 0;
  logic [7:0] fr[$];

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [8*MP-1:0] act, input logic [8*MP-1:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [7:0] c, input logic [7:0] l, input logic [8*MP-1:0] p);
    exp_t e;
    e.is_err = 1'b0; e.code = 3'd0; e.cmd = c; e.len = l; e.pay = p; e.exp_cyc = 0; e.chk_idle = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [2:0] code, input int at, input bit idle);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.cmd = 8'h00; e.len = 8'h00; e.pay = '0; e.exp_cyc = at; e.chk_idle = idle;
    exp_q.push_back(e);
  endtask

  // One 8N1 character; ack_end pulses frame_ack on the cycle the parser completes this byte.
  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit ack_end);
    @(posedge clk); #1; last_t0 = cyc; f_rx = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (OS) @(posedge clk);
      #1; f_rx = b[i];
    end
    repeat (OS) @(posedge clk);
    #1; f_rx = stop_bit;
    for (int c = 0; c < OS; c++) begin
      @(posedge clk); #1;
      if (ack_end && c == OS-2) frame_ack = 1'b1;
      if (ack_end && c == OS-1) frame_ack = 1'b0;
    end
    f_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] bs[$], input bit ack_last);
    for (int i = 0; i < bs.size(); i++)
      send_byte(bs[i], 1'b1, ack_last && (i == bs.size()-1));
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s: %0d expected events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_ack();
    @(posedge clk); #1; frame_ack = 1'b1;
    @(posedge clk); #1; frame_ack = 1'b0;
    check("ack_clears_valid", {95'd0, frame_valid}, '0);
  endtask

  // Monitor: pops an expectation on every err pulse and every frame delivery.
  initial begin
    exp_t e;
    logic fv_prev = 1'b0, ack_prev = 1'b0, err_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fv_prev = 1'b0; ack_prev = 1'b0; err_prev = 1'b0;
      end else begin
        if (err) begin
          check("err_single_cycle", {95'd0, err_prev}, '0);
          if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_err: got code %0d, required no event", err_code);
          end else begin
            e = exp_q.pop_front();
            check("event_is_err", {95'd0, e.is_err}, {95'd0, 1'b1});
            check("err_code", {93'd0, err_code}, {93'd0, e.code});
            if (e.exp_cyc != 0) check("err_cycle", (8*MP)'(cyc), (8*MP)'(e.exp_cyc));
            if (e.chk_idle)     check("busy_after_err", {95'd0, busy}, '0);
          end
        end
        if (frame_valid && (!fv_prev || ack_prev)) begin
          if (exp_q.size() == 0) begin
            tests++; failed++;
            $display("FAIL unexpected_frame: got cmd %h, required no event", cmd);
          end else begin
            e = exp_q.pop_front();
            check("event_is_frame", {95'd0, e.is_err}, '0);
            check("cmd", {88'd0, cmd}, {88'd0, e.cmd});
            check("cmd_len", {88'd0, cmd_len}, {88'd0, e.len});
            check("payload", payload, e.pay);
          end
        end
        fv_prev = frame_valid; ack_prev = frame_ack; err_prev = err;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_frame_valid"}, {95'd0, frame_valid}, '0);
    check({tag, "_cmd"},         {88'd0, cmd}, '0);
    check({tag, "_cmd_len"},     {88'd0, cmd_len}, '0);
    check({tag, "_payload"},     payload, '0);
    check({tag, "_err"},         {95'd0, err}, '0);
    check({tag, "_err_code"},    {93'd0, err_code}, '0);
    check({tag, "_busy"},        {95'd0, busy}, '0);
  endtask

  initial begin
    rst = 1'b1; f_rx = 1'b1; frame_ack = 1'b0;
    repeat (4) @(posedge clk);
    #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; check_reset_outputs("reset");

    // Good frame: checksum 16^03^01^02^03 = 15.
    fr = '{8'hAA, 8'h02, 8'h16, 8'h03, 8'h01, 8'h02, 8'h03, 8'h15, 8'h55};
    push_frame(8'h16, 8'd3, 96'h030201);
    send_frame(fr, 1'b0);
    drain("good_frame", 200);
    do_ack();
    check("cmd_kept_after_ack", {88'd0, cmd}, {88'd0, 8'h16});

    // Bad checksum, then the good frame again.
    fr = '{8'hAA, 8'h02, 8'h16, 8'h03, 8'h01, 8'h02, 8'h03, 8'h14, 8'h55};
    push_err(3'd3, 0, 1'b0);
    send_frame(fr, 1'b0);
    fr = '{8'hAA, 8'h02, 8'h16, 8'h03, 8'h01, 8'h02, 8'h03, 8'h15, 8'h55};
    push_frame(8'h16, 8'd3, 96'h030201);
    send_frame(fr, 1'b0);
    drain("bad_chk_then_good", 200);
    do_ack();

    // Zero-length frame: payload must read all zero.
    fr = '{8'hAA, 8'h02, 8'h2A, 8'h00, 8'h2A, 8'h55};
    push_frame(8'h2A, 8'd0, '0);
    send_frame(fr, 1'b0);
    drain("zero_len", 200);
    do_ack();

    // Length 13 > MAX_PAYLOAD.
    fr = '{8'hAA, 8'h02, 8'h16, 8'h0D};
    push_err(3'd2, 0, 1'b1);
    send_frame(fr, 1'b0);
    drain("len_too_big", 200);

    // Two frames, first not acked: second is dropped with overrun.
    fr = '{8'hAA, 8'h02, 8'h16, 8'h03, 8'h01, 8'h02, 8'h03, 8'h15, 8'h55};
    push_frame(8'h16, 8'd3, 96'h030201);
    send_frame(fr, 1'b0);
    fr = '{8'hAA, 8'h02, 8'h30, 8'h01, 8'h77, 8'h46, 8'h55};   // 30^01^77 = 46
    push_err(3'd7, 0, 1'b0);
    send_frame(fr, 1'b0);
    drain("overrun", 200);
    check("overrun_held_valid", {95'd0, frame_valid}, {95'd0, 1'b1});
    check("overrun_held_cmd", {88'd0, cmd}, {88'd0, 8'h16});
    check("overrun_held_payload", payload, 96'h030201);

    // Same second frame with ack on its completion cycle: delivered, valid stays 1.
    push_frame(8'h30, 8'd1, 96'h77);
    send_frame(fr, 1'b1);
    drain("ack_on_completion", 200);
    check("ack_completion_valid", {95'd0, frame_valid}, {95'd0, 1'b1});

    // Reset mid-payload while a frame is held: all outputs back to reset, no err.
    fr = '{8'hAA, 8'h02, 8'h16, 8'h03, 8'h01};
    send_frame(fr, 1'b0);
    @(posedge clk); #1; f_rx = 1'b0;
    repeat (20) @(posedge clk);
    #1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1; f_rx = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1; check_reset_outputs("midrst");
    fr = '{8'hAA, 8'h02, 8'h16, 8'h03, 8'h01, 8'h02, 8'h03, 8'h15, 8'h55};
    push_frame(8'h16, 8'd3, 96'h030201);
    send_frame(fr, 1'b0);
    drain("after_reset", 200);
    do_ack();

    // Stop bit low inside LEN byte: framing error, parser back to SYNC.
    fr = '{8'hAA, 8'h02, 8'h16};
    push_err(3'd5, 0, 1'b1);
    send_frame(fr, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0);
    drain("framing", 200);

    // Line idles after CMD: timeout exactly TO cycles after the CMD strobe.
    send_frame(fr, 1'b0);
    check("busy_mid_frame", {95'd0, busy}, {95'd0, 1'b1});
    push_err(3'd6, last_t0 + STB_LAT + TO, 1'b1);
    drain("timeout", TO + 300);

    check("final_valid", {95'd0, frame_valid}, '0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
